mem_bist_ctrl: RTL and testbench
================================

Name: mem_bist_ctrl

Overview:
- Built-in self-test master that sits directly upstream of the single-port memory block and drives its valid/ready request interface.
- On a start pulse it runs a four-phase march:
  - write the pattern to every address
  - read and compare every address
  - write the inverted pattern to every address
  - read and compare every address
- Reports pass/fail, error count and first failing address.

Parameters:
- WIDTH, 8, memory data width.
- DEPTH, 32, number of memory words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- PATTERN, 8'hA5, base data seed (WIDTH bits).

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a test run.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until next start or reset.
- pass  out  1  valid when done=1; 1 if err_count==0.
- err_count  out  ADDR_WIDTH+2  number of read mismatches; saturates at all-ones.
- first_fail_addr  out  ADDR_WIDTH  address of first mismatch; 0 if none.
- valid  out  1  memory request valid.
- wr_rd  out  1  1=write, 0=read.
- addr  out  ADDR_WIDTH  memory address.
- wdata  out  WIDTH  memory write data.
- rdata  in  WIDTH  memory read data; sampled on the accepting edge of a read.
- ready  in  1  memory accept/complete strobe.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (res).
  - While res=0: valid=0, wr_rd=0, addr=0, wdata=0, busy=0, done=0, pass=0, err_count=0, first_fail_addr=0; state=IDLE.
  - Reset mid-run aborts immediately; memory contents are left undefined.
- States: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DONE.
  - DONE -> WR0 on start.
  - IDLE -> WR0 on start.
  - start is ignored in WR0..RD1.
- On start: err_count, first_fail_addr, pass and done are cleared; busy=1; addr=0.
- Data per address a:
  - D(a) = PATTERN ^ a, with a zero-extended or truncated to WIDTH.
  - WR0 writes D(a); RD0 expects D(a).
  - WR1 writes ~D(a); RD1 expects ~D(a).
- Handshake:
  - valid, wr_rd, addr and wdata are driven from registers.
  - They hold stable while valid=1 and ready=0.
  - A transfer completes on a rising edge with valid=1 and ready=1.
  - The next request is presented the cycle after completion; valid may stay high back-to-back.
  - In read phases wdata=0.
- Address counter:
  - Increments on each completion.
  - At DEPTH-1 it wraps to 0 and the phase advances.
  - After the last RD1 completion: valid=0, state=DONE.
- Compare: on each read completion, rdata != expected increments err_count (saturating).
  - If this is the first mismatch of the run, first_fail_addr latches addr.
- Done:
  - DONE asserts done=1, busy=0, pass=(err_count==0); outputs hold.
  - With zero-wait memory (ready=1 whenever valid=1), done rises 4*DEPTH+1 cycles after the start edge.
- ready while valid=0 is ignored.

Optional Feature:
- Macro: MEM_BIST_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT (default 16) and output timeout (1 bit, reset 0) are added.
  - A per-transaction counter runs while valid=1 and ready=0.
  - When the counter reaches TIMEOUT the block drops valid and enters DONE with timeout=1 and pass=0; err_count is unchanged.
  - The counter clears on each completion.
- When undefined: the block waits for ready indefinitely, and the timeout port and counter are absent.

Decomposition:
- Package mem_bist_pkg holds:
  - the state enum (IDLE, WR0, RD0, WR1, RD1, DONE)
  - a phase-to-(wr_rd, invert) lookup
  - the default PATTERN constant
- One sub-module, mem_bist_err_log, holds the saturating err_count, first-fail latch and pass logic.
  - Inputs: cmp_en, mismatch, addr, clear.

Test Plan:
- Zero-wait memory model, DEPTH=32, WIDTH=8, PATTERN=8'hA5, start pulse -> done after 129 cycles, pass=1, err_count=0, first_fail_addr=0; 128 transfers seen in order WR0/RD0/WR1/RD1.
- Memory model with addr 5 bit0 stuck-at-1 -> RD0 reads 8'hA1 vs expected 8'hA0; done with pass=0, err_count=1, first_fail_addr=5.
- Memory ready asserted 3 cycles after valid -> valid/addr/wdata stable during wait; done after 4*32*4+1 cycles; pass=1.
- res driven low while in RD0 at addr 10 -> all outputs reset immediately; new start runs a full clean test with pass=1.
- start pulsed mid-WR1 -> ignored, run unaffected; start pulsed in DONE -> done/err_count cleared, new run begins.
- With MEM_BIST_TIMEOUT_EN, TIMEOUT=16, memory never asserts ready -> valid drops 16 cycles after first request; done=1, timeout=1, pass=0.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller:
// march phase encoding, per-phase access control lookup and default seed.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic wr;   // 1 = write phase
    logic inv;  // 1 = inverted pattern
  } phase_ctl_t;

  localparam logic [7:0] DEFAULT_PATTERN = 8'hA5;

  function automatic phase_ctl_t phase_ctl(input state_t s);
    phase_ctl_t c;
    c = '0;
    case (s)
      WR0:     c = '{wr: 1'b1, inv: 1'b0};
      RD0:     c = '{wr: 1'b0, inv: 1'b0};
      WR1:     c = '{wr: 1'b1, inv: 1'b1};
      RD1:     c = '{wr: 1'b0, inv: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      WR0:     n = RD0;
      RD0:     n = WR1;
      WR1:     n = RD1;
      default: n = DONE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_bist_err_log.sv
// Read-mismatch bookkeeping: saturating error counter, first failing
// address latch and the zero-error (pass) indication.
module mem_bist_err_log
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  clear,
  input  logic                  cmp_en,
  input  logic                  mismatch,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic                  pass
);

  // err_count can never return to zero inside a run, so it doubles as
  // the "no mismatch seen yet" flag for the first-fail latch.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      err_count       <= '0;
      first_fail_addr <= '0;
    end else if (clear) begin
      err_count       <= '0;
      first_fail_addr <= '0;
    end else if (cmp_en && mismatch) begin
      if (err_count != '1) err_count <= err_count + 1'b1;
      if (err_count == '0) first_fail_addr <= addr;
    end
  end

  assign pass = (err_count == '0);

endmodule

// File: rtl/mem_bist_ctrl.sv
// March BIST master (write P, read P, write ~P, read ~P) over a valid/ready
// memory port. Optional per-transaction timeout: define MEM_BIST_TIMEOUT_EN.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 32,
  parameter int unsigned      ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] PATTERN    = DEFAULT_PATTERN
`ifdef MEM_BIST_TIMEOUT_EN
  , parameter int unsigned    TIMEOUT    = 16
`endif
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready
`ifdef MEM_BIST_TIMEOUT_EN
  , output logic                timeout
`endif
);

  state_t                  state, nxt_state;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    nxt_valid;
  logic                    xfer, idle_start, last_addr;
  logic                    to_hit, to_flag, err_pass;
  phase_ctl_t              cur_ctl, nxt_ctl;
  logic [WIDTH-1:0]        cur_data, nxt_data, expected;

  function automatic logic [WIDTH-1:0] seed_data(input logic [ADDR_WIDTH-1:0] a);
    logic [WIDTH+ADDR_WIDTH-1:0] ext;
    ext = {{WIDTH{1'b0}}, a};
    return PATTERN ^ ext[WIDTH-1:0];
  endfunction

  assign xfer       = valid && ready;
  assign idle_start = start && ((state == IDLE) || (state == DONE));
  assign last_addr  = (addr == ADDR_WIDTH'(DEPTH - 1));

`ifdef MEM_BIST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit  = valid && !ready && (to_cnt == TW'(TIMEOUT - 1));
  assign to_flag = timeout;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (idle_start || xfer)  to_cnt <= '0;
      else if (valid && !ready) to_cnt <= to_cnt + 1'b1;
      if (idle_start)   timeout <= 1'b0;
      else if (to_hit)  timeout <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign to_flag = 1'b0;
`endif

  // Next request is computed ahead so the port registers load it on the
  // completing edge; during a stall every next-value equals the current one.
  always_comb begin
    nxt_state = state;
    nxt_addr  = addr;
    nxt_valid = valid;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt_state = WR0;
          nxt_addr  = '0;
          nxt_valid = 1'b1;
        end
      end
      default: begin
        if (to_hit) begin
          nxt_state = DONE;
          nxt_valid = 1'b0;
        end else if (xfer) begin
          if (last_addr) begin
            nxt_addr  = '0;
            nxt_state = next_phase(state);
            nxt_valid = (state != RD1);
          end else begin
            nxt_addr = addr + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    nxt_ctl  = phase_ctl(nxt_state);
    nxt_data = seed_data(nxt_addr);
    cur_ctl  = phase_ctl(state);
    cur_data = seed_data(addr);
    expected = cur_ctl.inv ? ~cur_data : cur_data;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
      valid <= 1'b0;
      wr_rd <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= nxt_state;
      valid <= nxt_valid;
      addr  <= nxt_addr;
      wr_rd <= nxt_ctl.wr;
      wdata <= nxt_ctl.wr ? (nxt_ctl.inv ? ~nxt_data : nxt_data) : '0;
      busy  <= (nxt_state != IDLE) && (nxt_state != DONE);
      // done/pass follow one cycle into DONE so the last compare is counted
      if (idle_start) begin
        done <= 1'b0;
        pass <= 1'b0;
      end else if (state == DONE) begin
        done <= 1'b1;
        pass <= err_pass && !to_flag;
      end
    end
  end

  mem_bist_err_log #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_err_log (
    .clk             (clk),
    .res             (res),
    .clear           (idle_start),
    .cmp_en          (xfer && !wr_rd),
    .mismatch        (rdata != expected),
    .addr            (addr),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr),
    .pass            (err_pass)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a behavioural memory (configurable
// wait states, stuck-at fault). Timeout case built when MEM_BIST_TIMEOUT_EN.
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass, valid, wr_rd;
  logic [6:0] err_count;
  logic [4:0] first_fail_addr, addr;
  logic [7:0] wdata, rdata;
  logic       ready = 1'b0;
`ifdef MEM_BIST_TIMEOUT_EN
  logic       timeout;
`endif

  logic [7:0] mem [32];
  logic       stuck = 1'b0;
  int         lat = 0;
  int         wcnt = 0;
  int         xfer_idx = 0;
  int         order_err = 0;
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic       pv, pw;
  logic [4:0] pa;
  logic [7:0] pd;
  int         vecs = 0;
  int         miscompares = 0;
  int         cyc;

  always #5 clk = ~clk;

  mem_bist_ctrl #(
    .WIDTH   (8),
    .DEPTH   (32),
    .PATTERN (8'hA5)
`ifdef MEM_BIST_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) dut (
    .clk             (clk),
    .res             (res),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr),
    .valid           (valid),
    .wr_rd           (wr_rd),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .ready           (ready)
`ifdef MEM_BIST_TIMEOUT_EN
    , .timeout       (timeout)
`endif
  );

  assign rdata = mem[addr] | ((stuck && addr == 5'd5) ? 8'h01 : 8'h00);

  // Memory model: decides ready for the next rising edge, logs the transfer
  // that will complete there against the expected march order.
  always @(negedge clk) begin
    if (prev_stall && (valid !== pv || wr_rd !== pw || addr !== pa || wdata !== pd))
      stab_err++;
    if (valid) begin
      if (lat < 0) begin
        ready = 1'b0;
      end else if (wcnt >= lat) begin
        ready = 1'b1;
        wcnt  = 0;
        begin
          int ph, a;
          logic       ewr;
          logic [7:0] d, ewd;
          ph  = xfer_idx / 32;
          a   = xfer_idx % 32;
          ewr = (ph == 0) || (ph == 2);
          d   = 8'hA5 ^ 8'(a);
          ewd = ewr ? ((ph == 2) ? ~d : d) : 8'h00;
          if (xfer_idx >= 128 || addr != 5'(a) || wr_rd != ewr || wdata != ewd)
            order_err++;
          if (wr_rd) mem[addr] = wdata;
          xfer_idx++;
        end
      end else begin
        ready = 1'b0;
        wcnt++;
      end
    end else begin
      ready = (lat == 0);
      wcnt  = 0;
    end
    prev_stall = valid && !ready;
    pv = valid; pw = wr_rd; pa = addr; pd = wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input bit fresh);
    @(negedge clk);
    start = 1'b1;
    if (fresh) begin
      xfer_idx  = 0;
      order_err = 0;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges after the start edge until done is seen.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    if (!done) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic check_clean(input string tag);
    check({tag, "_pass"}, pass, 1);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_ffa"}, first_fail_addr, 0);
    check({tag, "_xfers"}, xfer_idx, 128);
    check({tag, "_order"}, order_err, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_wr_rd", wr_rd, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy_done_pass", {busy, done, pass}, 0);
    check("rst_err_ffa", {err_count, first_fail_addr}, 0);
    @(negedge clk);
    res = 1'b1;

    // Clean zero-wait run
    pulse_start(1);
    check("start_busy", busy, 1);
    check("start_valid", valid, 1);
    wait_done(2000, cyc);
    check("clean_cycles", cyc, 129);
    check("clean_busy", busy, 0);
    check_clean("clean");

    // Stuck-at-1 on bit0 of address 5
    stuck = 1'b1;
    pulse_start(1);
    wait_done(2000, cyc);
    check("stuck_cycles", cyc, 129);
    check("stuck_pass", pass, 0);
    check("stuck_err", err_count, 1);
    check("stuck_ffa", first_fail_addr, 5);

    // Restart from DONE clears status; a start mid-WR1 is ignored
    stuck = 1'b0;
    pulse_start(1);
    check("restart_done", done, 0);
    check("restart_err", err_count, 0);
    check("restart_busy", busy, 1);
    cyc = 0;
    while (xfer_idx < 70 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_wr1", (xfer_idx >= 64 && xfer_idx < 96), 1);
    pulse_start(0);
    wait_done(2000, cyc);
    check_clean("midstart");

    // Three wait states per transfer
    lat = 3;
    stab_err = 0;
    pulse_start(1);
    wait_done(3000, cyc);
    check("wait_cycles", cyc, 513);
    check("wait_stable", stab_err, 0);
    check_clean("wait");
    lat = 0;

    // Asynchronous reset while reading address 10 in RD0
    pulse_start(1);
    cyc = 0;
    while (!(valid && !wr_rd && addr == 5'd10 && xfer_idx >= 32 && xfer_idx < 64) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_rd0_a10", {valid, wr_rd, addr}, {1'b1, 1'b0, 5'd10});
    res = 1'b0;
    #1;
    check("abort_port", {valid, wr_rd, addr, wdata}, 0);
    check("abort_status", {busy, done, pass, err_count, first_fail_addr}, 0);
    @(negedge clk);
    res = 1'b1;
    pulse_start(1);
    wait_done(2000, cyc);
    check("post_abort_cycles", cyc, 129);
    check_clean("post_abort");

`ifdef MEM_BIST_TIMEOUT_EN
    // Memory never answers
    check("to_reset_val", timeout, 0);
    lat = -1;
    pulse_start(1);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!valid) break;
    end
    check("to_valid_drop", cyc, 16);
    @(posedge clk);
    #1;
    check("to_done", done, 1);
    check("to_flag", timeout, 1);
    check("to_pass", pass, 0);
    check("to_err", err_count, 0);
    lat = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
